// File: rtl/mux_scan_n.sv
// Registered N-channel mux with manual select and round-robin scan (DWELL cycles per channel).
// Optional MUX_SCAN_MASK_EN adds a per-channel enable MASK that scan skips over.
module mux_scan_n #(
    parameter int unsigned BITS     = 4,
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned SELW     = 4,
    parameter int unsigned DWELL    = 1000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CHANNELS*BITS-1:0] D,
    input  logic [SELW-1:0]          SEL,
    input  logic                     MODO,
    input  logic                     HOLD,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CHANNELS-1:0]      MASK,
`endif
    output logic [BITS-1:0]          MUX_OUT,
    output logic [SELW-1:0]          CANAL,
    output logic                     VALID,
    output logic                     FIM_CICLO
);

    localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned IDXW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

    logic [CNTW-1:0]     count;
    logic [CNTW-1:0]     count_next;
    logic                modo_q;
    logic [SELW-1:0]     canal_next;
    logic                fim_next;
    logic                valid_next;
    logic [BITS-1:0]     data_next;

    logic [CHANNELS-1:0] enabled;
    logic [BITS-1:0]     chan [CHANNELS];

    logic [SELW-1:0]     adv_idx;
    logic                adv_wrap;
    logic                adv_found;
    int unsigned         cand;

`ifdef MUX_SCAN_MASK_EN
    assign enabled = MASK;
`else
    assign enabled = '1;
`endif

    // Unpack the data bus into one entry per channel
    for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_chan
        assign chan[k] = D[k*BITS +: BITS];
    end

    // Next enabled channel after CANAL, searched cyclically; wrap flags a high-to-low crossing
    always_comb begin
        adv_idx   = CANAL;
        adv_wrap  = 1'b0;
        adv_found = 1'b0;
        cand      = 0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            cand = 32'(CANAL) + i;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            if (!adv_found && enabled[IDXW'(cand)]) begin
                adv_found = 1'b1;
                adv_idx   = SELW'(cand);
                adv_wrap  = (cand <= 32'(CANAL));
            end
        end
    end

    // Channel and dwell-counter next state
    always_comb begin
        canal_next = CANAL;
        count_next = count;
        fim_next   = 1'b0;
        if (!MODO) begin
            canal_next = SEL;
            count_next = '0;
        end else if (!modo_q) begin
            // Entering scan: restart from channel 0 with a full dwell
            canal_next = '0;
            count_next = '0;
        end else if (!HOLD) begin
            if (count < CNT_LAST) begin
                count_next = count + CNTW'(1);
            end else begin
                count_next = '0;
                if (adv_found) begin
                    canal_next = adv_idx;
                    fim_next   = adv_wrap;
                end
            end
        end
    end

    // Out-of-range or disabled channels read as all ones
    always_comb begin
        data_next = '1;
        if ((32'(canal_next) < CHANNELS) && enabled[IDXW'(canal_next)]) begin
            data_next = chan[IDXW'(canal_next)];
        end
    end

    assign valid_next = (canal_next != CANAL);

    // modo_q resets to 1 so scan straight out of reset keeps a full first dwell
    always_ff @(posedge clock) begin
        if (reset) begin
            MUX_OUT   <= '0;
            CANAL     <= '0;
            VALID     <= 1'b0;
            FIM_CICLO <= 1'b0;
            count     <= '0;
            modo_q    <= 1'b1;
        end else begin
            MUX_OUT   <= data_next;
            CANAL     <= canal_next;
            VALID     <= valid_next;
            FIM_CICLO <= fim_next;
            count     <= count_next;
            modo_q    <= MODO;
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Randomized self-checking bench for mux_scan_n against a cycle-level behavioural model.
module tb_mux_scan_n;

    localparam int unsigned BITS     = 4;
    localparam int unsigned CHANNELS = 16;
    localparam int unsigned SELW     = 4;
    localparam int unsigned DWELL    = 4;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [CHANNELS*BITS-1:0] D;
    logic [SELW-1:0]          SEL;
    logic                     MODO;
    logic                     HOLD;
    logic [CHANNELS-1:0]      MASK;
    logic [BITS-1:0]          MUX_OUT;
    logic [SELW-1:0]          CANAL;
    logic                     VALID;
    logic                     FIM_CICLO;

    logic [BITS-1:0] dv [CHANNELS];

    int checks = 0;
    int errors = 0;

    int m_canal, m_count, m_out;
    bit m_valid, m_fim, m_prev;

    mux_scan_n #(
        .BITS(BITS), .CHANNELS(CHANNELS), .SELW(SELW), .DWELL(DWELL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .D(D),
        .SEL(SEL),
        .MODO(MODO),
        .HOLD(HOLD),
`ifdef MUX_SCAN_MASK_EN
        .MASK(MASK),
`endif
        .MUX_OUT(MUX_OUT),
        .CANAL(CANAL),
        .VALID(VALID),
        .FIM_CICLO(FIM_CICLO)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pack_d();
        for (int k = 0; k < int'(CHANNELS); k++) begin
            D[k*BITS +: BITS] = dv[k];
        end
    endtask

    function automatic bit en(input int idx);
`ifdef MUX_SCAN_MASK_EN
        return ((MASK >> idx) & 1) != 0;
`else
        return (idx >= 0);
`endif
    endfunction

    function automatic int chan_val(input int idx);
        if (idx >= int'(CHANNELS) || !en(idx)) return (1 << BITS) - 1;
        return int'(dv[idx]);
    endfunction

    // One clock edge of the specified behaviour, using the inputs currently driven
    task automatic model_edge();
        int nc, ncount;
        bit f;
        if (reset) begin
            m_canal = 0; m_count = 0; m_out = 0;
            m_valid = 0; m_fim = 0; m_prev = 1;
            return;
        end
        nc = m_canal; ncount = m_count; f = 0;
        if (!MODO) begin
            nc = int'(SEL);
            ncount = 0;
        end else if (!m_prev) begin
            nc = 0;
            ncount = 0;
        end else if (!HOLD) begin
            ncount = (m_count + 1) % int'(DWELL);
            if (ncount == 0) begin
                for (int i = 1; i <= int'(CHANNELS); i++) begin
                    int c;
                    c = (m_canal + i) % int'(CHANNELS);
                    if (en(c)) begin
                        nc = c;
                        f = (c <= m_canal);
                        break;
                    end
                end
            end
        end
        m_valid = (nc != m_canal);
        m_fim   = f;
        m_canal = nc;
        m_count = ncount;
        m_out   = chan_val(nc);
        m_prev  = MODO;
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        @(negedge clock);
        check("mux_out", 32'(MUX_OUT), 32'(m_out));
        check("canal", 32'(CANAL), 32'(m_canal));
        check("valid", 32'(VALID), 32'(m_valid));
        check("fim_ciclo", 32'(FIM_CICLO), 32'(m_fim));
    endtask

    initial begin
        for (int k = 0; k < int'(CHANNELS); k++) dv[k] = BITS'(k);
        pack_d();
        reset = 1'b1; SEL = '0; MODO = 1'b0; HOLD = 1'b0; MASK = '1;

        // Reset held two cycles, then idle manual on channel 0
        step(); step();
        reset = 1'b0;
        repeat (3) step();
        check("rst_canal", 32'(CANAL), 32'd0);
        check("rst_out", 32'(MUX_OUT), 32'd0);

        // Manual select 3 -> 9, then data change on channel 9
        SEL = 4'd3; step();
        SEL = 4'd9; step();
        check("man_out9", 32'(MUX_OUT), 32'd9);
        check("man_valid", 32'(VALID), 32'd1);
        step();
        check("man_valid_drop", 32'(VALID), 32'd0);
        dv[9] = 4'd5; pack_d(); step();
        check("man_data_track", 32'(MUX_OUT), 32'd5);
        dv[9] = 4'd9; pack_d(); step();

        // Scan from reset: one full cycle of 16 channels x 4 cycles
        reset = 1'b1; MODO = 1'b1; step();
        reset = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (i == 4)  check("scan_step1", 32'(CANAL), 32'd1);
            if (i == 63) check("scan_last", 32'(CANAL), 32'd15);
            if (i == 64) check("scan_wrap_fim", 32'(FIM_CICLO), 32'd1);
        end

        // Hold at channel 6 with count 2
        reset = 1'b1; step();
        reset = 1'b0;
        repeat (26) step();
        check("hold_at6", 32'(CANAL), 32'd6);
        HOLD = 1'b1;
        repeat (10) step();
        check("hold_frozen", 32'(CANAL), 32'd6);
        HOLD = 1'b0;
        step();
        check("hold_release1", 32'(CANAL), 32'd6);
        step();
        check("hold_release2", 32'(CANAL), 32'd7);

        // Reset mid-dwell at channel 11
        reset = 1'b1; step();
        reset = 1'b0;
        repeat (45) step();
        check("mid_at11", 32'(CANAL), 32'd11);
        reset = 1'b1; step();
        check("mid_rst_canal", 32'(CANAL), 32'd0);
        check("mid_rst_out", 32'(MUX_OUT), 32'd0);
        reset = 1'b0;
        repeat (3) step();
        check("mid_full_dwell", 32'(CANAL), 32'd0);
        step();
        check("mid_resume", 32'(CANAL), 32'd1);

`ifdef MUX_SCAN_MASK_EN
        // Sparse mask: 0, 2, 15, 0 ...
        MASK = 16'h8005;
        reset = 1'b1; step();
        reset = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (i == 4)  check("mask_to2", 32'(CANAL), 32'd2);
            if (i == 8)  check("mask_to15", 32'(CANAL), 32'd15);
            if (i == 12) check("mask_wrap_fim", 32'(FIM_CICLO), 32'd1);
        end
        MASK = '0;
        repeat (8) step();
        check("mask_zero_out", 32'(MUX_OUT), 32'hF);
        MASK = '1;
`endif

        // Randomized mix of modes, hold, select, data and resets
        for (int n = 0; n < 1200; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) MODO = ~MODO;
            HOLD = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) SEL = SELW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                dv[$urandom_range(0, CHANNELS - 1)] = BITS'($urandom);
                pack_d();
            end
`ifdef MUX_SCAN_MASK_EN
            if ($urandom_range(0, 49) == 0) begin
                MASK = ($urandom_range(0, 4) == 0) ? '0 : CHANNELS'($urandom);
            end
`endif
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
